tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive-side end of the team's 4:1 time-division link: the transmitter multiplexes four channels onto one shared bus; this block redistributes each slot to one of four held output registers.
- Tracks slot position with a 2-bit channel counter aligned by a frame-sync marker on slot 0.
- Flags misalignment, and pulses a per-channel update strobe plus an end-of-frame strobe.
- Sits directly downstream of the link bus and upstream of per-channel consumers.

Parameters:
- WIDTH, 8, sample width per slot in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- din  input  WIDTH  slot data from the shared bus.
- din_valid  input  1  din holds a slot this cycle.
- frame_sync  input  1  qualifies a slot as channel 0 (a, S=00); ignored when din_valid=0.
- out_a, out_b, out_c, out_d  output  WIDTH each  held samples for channels 0..3.
- out_valid  output  4  one-hot pulse; bit n set for one cycle when channel n register updates.
- frame_done  output  1  one-cycle pulse when channel 3 (d) updates.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on alignment error.

Behaviour:
- Reset (async, rst_n=0):
  - out_a..out_d=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
  - state=HUNT, ch=0.
- All outputs are registered. Latency is one cycle: an accepted slot at edge k is visible on out_x/out_valid after edge k.
- State HUNT:
  - din_valid=1 & frame_sync=1: write out_a, out_valid=0001, ch=1, go LOCKED.
  - Any other din_valid slot: discarded, no strobe, no error.
- State LOCKED (only slots with din_valid=1 act):
  - frame_sync=0, ch!=0: write channel ch, out_valid=onehot(ch), ch=ch+1. ch wraps 3->0. frame_done=1 when ch==3.
  - frame_sync=1, ch==0: normal slot 0. Write out_a, ch=1.
  - frame_sync=1, ch!=0 (early sync): sync_err=1, realign. Write out_a, out_valid=0001, ch=1, stay LOCKED. No frame_done.
  - frame_sync=0, ch==0 (missing sync): sync_err=1, slot discarded, ch=0, go HUNT, locked=0 next cycle.
- din_valid=0: nothing changes; strobes deassert; output registers hold.
- Strobes are single-cycle pulses and are never held across idle cycles.
- Reset asserted mid-frame: immediate return to reset values; partial frame is lost.
- Back-to-back valid slots are accepted every cycle with no bubbles.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Adds input din_par (1 bit) and output par_err (1 bit pulse).
  - Even parity is checked over {din, din_par}.
  - On mismatch for a slot that would be written: the register is not written, out_valid stays 0 for that slot, par_err=1.
  - ch still advances, and state/sync handling is unchanged. frame_done still pulses on a slot-3 parity failure.
- Undefined: ports din_par/par_err are absent; no checking.

Decomposition:
- Package tdm_pkg:
  - NUM_CH=4, CH_W=2.
  - State enum {HUNT, LOCKED}.
  - Channel index constants CH_A..CH_D.
- One sub-module: tdm_slot_counter.
  - Holds the 2-bit ch and the HUNT/LOCKED FSM.
  - Produces ch, locked, sync_err and the slot-accept decision.
- Top level holds the four data registers and the strobe logic.

Test Plan:
- Reset, then sync+valid din=8'h11, followed by valid 8'h22, 8'h33, 8'h44 on consecutive cycles -> out_a..d=11,22,33,44; out_valid sequence 0001,0010,0100,1000; frame_done on the 4th; locked=1 after first edge.
- Valid slots 8'hAA, 8'hBB without sync in HUNT -> no writes, outputs stay 0, sync_err=0, locked=0.
- Locked, sync arrives at ch=2 with din=8'h5A -> sync_err pulse, out_a=5A, out_valid=0001, next slot writes out_b.
- Locked, complete frame, then next slot valid without sync -> sync_err pulse, no write, locked=0, state HUNT.
- Gaps of 3 idle cycles between slots -> outputs hold; strobes only on valid cycles; ordering a,b,c,d preserved.
- rst_n low after two slots of a frame -> all outputs 0 immediately (asynchronously), HUNT; new sync frame decodes correctly.
- (With TDM_DEMUX_PARITY_EN) slot b with bad parity, din=8'h01, din_par=0 -> par_err pulse, out_b unchanged, next slot writes out_c.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive demultiplexer.
// Optional even-parity checking is enabled with `define TDM_DEMUX_PARITY_EN.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [CH_W-1:0] CH_A = 2'd0;
  localparam logic [CH_W-1:0] CH_B = 2'd1;
  localparam logic [CH_W-1:0] CH_C = 2'd2;
  localparam logic [CH_W-1:0] CH_D = 2'd3;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position tracker: HUNT/LOCKED alignment FSM plus the 2-bit channel counter.
// Decides per valid slot whether it is written and to which channel.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din_valid_i,
  input  logic            frame_sync_i,
  output state_e          state_o,
  output logic [CH_W-1:0] ch_o,
  output logic            sync_err_o,
  output logic            accept_o,
  output logic [CH_W-1:0] wr_ch_o
);

  // Handshake: din_valid_i qualifies one slot for exactly one cycle; there is
  // no backpressure, so every valid slot is resolved on the edge it is seen.

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            sync_err_q, sync_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      ch_q       <= CH_A;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    sync_err_d = 1'b0;
    if (din_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync_i) begin
            ch_d    = CH_B;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync_i) begin
            // A sync always realigns to slot 0; it is an error only if early.
            ch_d       = CH_B;
            sync_err_d = (ch_q != CH_A);
          end else if (ch_q != CH_A) begin
            ch_d = ch_q + 2'd1;
          end else begin
            ch_d       = CH_A;
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    accept_o = 1'b0;
    wr_ch_o  = ch_q;
    if (din_valid_i) begin
      if (frame_sync_i) begin
        accept_o = 1'b1;
        wr_ch_o  = CH_A;
      end else if (state_q == LOCKED && ch_q != CH_A) begin
        accept_o = 1'b1;
      end
    end
  end

  assign state_o    = state_q;
  assign ch_o       = ch_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4:1 TDM receive demultiplexer: routes aligned slots into four held registers
// with per-channel and end-of-frame strobes. Parity via `define TDM_DEMUX_PARITY_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             din_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  state_e          state;
  logic [CH_W-1:0] ch;
  logic            accept;
  logic [CH_W-1:0] wr_ch;
  logic            par_ok;
  logic            wr_en;

  logic [WIDTH-1:0]  data_q [NUM_CH];
  logic [WIDTH-1:0]  data_d [NUM_CH];
  logic [NUM_CH-1:0] out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;

  tdm_slot_counter u_slot_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_valid_i  (din_valid),
    .frame_sync_i (frame_sync),
    .state_o      (state),
    .ch_o         (ch),
    .sync_err_o   (sync_err),
    .accept_o     (accept),
    .wr_ch_o      (wr_ch)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic par_err_q;
  logic par_err_d;

  // Even parity: {din, din_par} must hold an even number of ones.
  assign par_ok    = ~(^{din, din_par});
  assign par_err_d = accept & ~par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign wr_en = accept & par_ok;

  always_comb begin
    data_d = data_q;
    if (wr_en) data_d[wr_ch] = din;
  end

  assign out_valid_d = wr_en ? ch_onehot(wr_ch) : '0;
  // End of frame marks the slot-3 position even when its data was rejected.
  assign frame_done_d = accept && (wr_ch == CH_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_a      = data_q[CH_A];
  assign out_b      = data_q[CH_B];
  assign out_c      = data_q[CH_C];
  assign out_d      = data_q[CH_D];
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: alignment, realignment, loss of sync, idle gaps,
// asynchronous reset mid-frame and, with TDM_DEMUX_PARITY_EN, parity rejection.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_valid;
  logic       frame_done, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic       din_par;
  logic       par_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par    (din_par),
    .par_err    (par_err),
`endif
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic [3:0] ov, input logic fd,
                         input logic lk, input logic se);
    chk({tag, ".out_a"},      out_a,      a);
    chk({tag, ".out_b"},      out_b,      b);
    chk({tag, ".out_c"},      out_c,      c);
    chk({tag, ".out_d"},      out_d,      d);
    chk({tag, ".out_valid"},  out_valid,  ov);
    chk({tag, ".frame_done"}, frame_done, fd);
    chk({tag, ".locked"},     locked,     lk);
    chk({tag, ".sync_err"},   sync_err,   se);
  endtask

  // Presents one bus cycle, then samples 1 time unit after the active edge.
  task automatic slot(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = ^d;
`endif
    @(posedge clk);
    #1;
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic slot_par(input logic s, input logic [7:0] d, input logic p);
    @(negedge clk);
    din_valid  = 1'b1;
    frame_sync = s;
    din        = d;
    din_par    = p;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 8'h00;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsynchronised slots while hunting are dropped silently.
    slot(1'b1, 1'b0, 8'hAA);
    chk_all("hunt_aa", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 8'hBB);
    chk_all("hunt_bb", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);

    // First aligned frame, back to back.
    slot(1'b1, 1'b1, 8'h11);
    chk_all("f1_a", 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h22);
    chk_all("f1_b", 8'h11, 8'h22, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h33);
    chk_all("f1_c", 8'h11, 8'h22, 8'h33, 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h44);
    chk_all("f1_d", 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 1'b1, 1'b1, 1'b0);
    slot(1'b0, 1'b0, 8'hFF);
    chk_all("f1_idle", 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Frame with three idle cycles between slots; idle data must be ignored.
    slot(1'b1, 1'b1, 8'h55);
    chk_all("gap_a", 8'h55, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, 1'b1, 8'hEE);
      chk_all("gap_idle_a", 8'h55, 8'h22, 8'h33, 8'h44, 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    slot(1'b1, 1'b0, 8'h66);
    chk_all("gap_b", 8'h55, 8'h66, 8'h33, 8'h44, 4'b0010, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, 1'b0, 8'hEE);
      chk_all("gap_idle_b", 8'h55, 8'h66, 8'h33, 8'h44, 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    slot(1'b1, 1'b0, 8'h77);
    chk_all("gap_c", 8'h55, 8'h66, 8'h77, 8'h44, 4'b0100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      slot(1'b0, 1'b0, 8'hEE);
      chk_all("gap_idle_c", 8'h55, 8'h66, 8'h77, 8'h44, 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    slot(1'b1, 1'b0, 8'h88);
    chk_all("gap_d", 8'h55, 8'h66, 8'h77, 8'h88, 4'b1000, 1'b1, 1'b1, 1'b0);

    // Early sync at ch=2 realigns to channel a.
    slot(1'b1, 1'b1, 8'h91);
    chk_all("es_a", 8'h91, 8'h66, 8'h77, 8'h88, 4'b0001, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h92);
    chk_all("es_b", 8'h91, 8'h92, 8'h77, 8'h88, 4'b0010, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b1, 8'h5A);
    chk_all("es_sync", 8'h5A, 8'h92, 8'h77, 8'h88, 4'b0001, 1'b0, 1'b1, 1'b1);
    slot(1'b1, 1'b0, 8'h93);
    chk_all("es_next_b", 8'h5A, 8'h93, 8'h77, 8'h88, 4'b0010, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'hC3);
    chk_all("es_c", 8'h5A, 8'h93, 8'hC3, 8'h88, 4'b0100, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'hE4);
    chk_all("es_d", 8'h5A, 8'h93, 8'hC3, 8'hE4, 4'b1000, 1'b1, 1'b1, 1'b0);

    // Missing sync on slot 0 drops lock and discards the slot.
    slot(1'b1, 1'b0, 8'h77);
    chk_all("miss_sync", 8'h5A, 8'h93, 8'hC3, 8'hE4, 4'b0000, 1'b0, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 8'h12);
    chk_all("miss_hunt", 8'h5A, 8'h93, 8'hC3, 8'hE4, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after two slots of a frame.
    slot(1'b1, 1'b1, 8'h21);
    chk_all("rst_a", 8'h21, 8'h93, 8'hC3, 8'hE4, 4'b0001, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h22);
    chk_all("rst_b", 8'h21, 8'h22, 8'hC3, 8'hE4, 4'b0010, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b1;
    slot(1'b1, 1'b1, 8'h31);
    chk_all("post_a", 8'h31, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h32);
    chk_all("post_b", 8'h31, 8'h32, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h33);
    chk_all("post_c", 8'h31, 8'h32, 8'h33, 8'h00, 4'b0100, 1'b0, 1'b1, 1'b0);
    slot(1'b1, 1'b0, 8'h34);
    chk_all("post_d", 8'h31, 8'h32, 8'h33, 8'h34, 4'b1000, 1'b1, 1'b1, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
    slot_par(1'b1, 8'h10, 1'b1);
    chk_all("par_a", 8'h10, 8'h32, 8'h33, 8'h34, 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("par_a.par_err", par_err, 1'b0);
    slot_par(1'b0, 8'h01, 1'b0);
    chk_all("par_bad_b", 8'h10, 8'h32, 8'h33, 8'h34, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("par_bad_b.par_err", par_err, 1'b1);
    slot_par(1'b0, 8'h03, 1'b0);
    chk_all("par_c", 8'h10, 8'h32, 8'h03, 8'h34, 4'b0100, 1'b0, 1'b1, 1'b0);
    chk("par_c.par_err", par_err, 1'b0);
    slot_par(1'b0, 8'h07, 1'b0);
    chk_all("par_bad_d", 8'h10, 8'h32, 8'h03, 8'h34, 4'b0000, 1'b1, 1'b1, 1'b0);
    chk("par_bad_d.par_err", par_err, 1'b1);
`endif

    slot(1'b0, 1'b0, 8'h00);
    chk("final_idle.out_valid", out_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
